riscv_mc_ctrl: RTL and testbench
================================

Name: riscv_mc_ctrl

Overview:
- Main controller for the multicycle RV32I core variant. One unified instruction/data memory port and one ALU are reused across cycles.
- Sequences the datapath through a Moore FSM (fetch, decode, execute, memory, writeback).
- Adds a ready handshake so the shared memory may insert wait states.
- Decodes ALU operation and immediate format from the fetched instruction register.

Parameters:
- XLen, 32, width of the performance counters.
- ILen, 32, instruction width; only fields op/funct3/funct7[5] are consumed.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- op_i  in  7  instruction register [6:0]
- funct3_i  in  3  instruction register [14:12]
- funct7b5_i  in  1  instruction register [30]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write enable
- adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load the instruction register (and OldPC)
- pc_write_o  out  1  update the PC
- reg_write_o  out  1  register-file write enable
- result_src_o  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a_o  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b_o  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- imm_src_o  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_o  out  1  sticky illegal-opcode flag

Behaviour:
- Outputs are Moore-style from the state, except the gating on mem_ready_i and zero_i noted below. Any output not listed for a state is 0.
- Reset: state <= FETCH. During a cycle with rst_i=1, mem_req_o, mem_we_o, ir_write_o, pc_write_o and reg_write_o are forced to 0, and illegal_o is cleared.
- Reset mid-instruction abandons the instruction; no partial register write occurs.
- FETCH:
  - mem_req=1, adr_src=0, a=00, b=10, alu add, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready_i=1. Then -> DECODE; otherwise stay in FETCH.
- DECODE: a=01, b=01, alu add (computes the branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: a=10, b=01, alu add. Next -> MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready_i=1, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1. Next -> FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. mem_we is held stable until mem_ready_i=1, then -> FETCH.
- EXECR: a=10, b=00, ALUOp=10. Next -> ALUWB.
- EXECI: a=10, b=01, ALUOp=10. Next -> ALUWB.
- ALUWB: result_src=00, reg_write=1. Next -> FETCH.
- BEQ: a=10, b=00, alu sub, result_src=00. pc_write = zero_i. Next -> FETCH.
- JAL: a=01, b=10, alu add, result_src=00, pc_write=1. Next -> ALUWB.
- TRAP: illegal_o=1; all enables 0; stays in TRAP until reset.
- imm_src (combinational from op_i; default 00):
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
- ALU decode, ALUOp=10 (R/I execute):
  - funct3 000: sub if (op_i[5] & funct7b5_i), else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - other funct3 values: add.
- Cycle counts with zero wait states:
  - lw = 5
  - sw = 4
  - R/I = 4
  - beq = 3
  - jal = 4

Optional Feature:
- Macro: RISCV_MC_CTRL_PERF_CNT_EN.
- When defined, adds two output ports:
  - cycle_cnt_o [XLen-1:0]: increments every cycle not in reset.
  - instret_cnt_o [XLen-1:0]: increments on each transition into FETCH from MEMWB, MEMWRITE (on ready), ALUWB or BEQ.
- Both counters wrap modulo 2^XLen and clear on rst_i.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package riscv_mc_pkg holds:
  - state_e enum (FETCH … TRAP)
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL)
  - alu_ctrl_e, imm_src_e, result_src_e, alu_src_a_e, alu_src_b_e
- One sub-module, riscv_alu_dec, holds the combinational mapping from ALUOp/funct3/funct7b5/op5 to alu_control.

Test Plan:
- Reset, then op=0000011 with mem_ready tied 1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and result_src=01 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_we held 1 for 4 cycles; no state advance until ready; then FETCH.
- beq, funct3 000: zero_i=1 -> pc_write=1 in BEQ; zero_i=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
- R-type funct3 000, funct7b5=1 -> alu_control=001 in EXECR. I-type with same bits (op[5]=0) -> 000. funct3 111 -> 010.
- op=1111111 -> TRAP; illegal_o=1 held for 10 cycles; assert rst_i -> illegal_o=0 and FETCH next.
- Reset asserted in MEMWB -> reg_write=0 that cycle; with RISCV_MC_CTRL_PERF_CNT_EN, 3 back-to-back addi -> instret_cnt_o=3, cycle_cnt_o=12.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multicycle RV32I controller.
// State, opcode and datapath-select encodings used by the FSM and ALU decoder.
// Purely declarative; no logic beyond the immediate-format helper.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    // ALUOp: fixed add, fixed sub, or decode from funct fields
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    // Immediate format selected purely from the opcode; I-format otherwise
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_alu_dec.sv
// ALU control decoder: maps ALUOp/funct3/funct7[5]/op[5] to an ALU operation.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module riscv_alu_dec
    import riscv_mc_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_ctrl_e  alu_control
);

    // Fixed add/sub for address and branch work, funct decode for R/I execute
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type; addi with imm[10]=1 must stay an add
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I main controller: Moore FSM steering a shared memory port and ALU.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles with zero memory wait states.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready_i; RISCV_MC_CTRL_PERF_CNT_EN adds counters.
module riscv_mc_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int XLen = 32,
    parameter int ILen = 32
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      op_i,
    input  logic [2:0]      funct3_i,
    input  logic            funct7b5_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic            adr_src_o,
    output logic            ir_write_o,
    output logic            pc_write_o,
    output logic            reg_write_o,
    output logic [1:0]      result_src_o,
    output logic [1:0]      alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [1:0]      imm_src_o,
    output logic [2:0]      alu_control_o,
    output logic            illegal_o
`ifdef RISCV_MC_CTRL_PERF_CNT_EN
    ,
    output logic [XLen-1:0] cycle_cnt_o,
    output logic [XLen-1:0] instret_cnt_o
`endif
);

    // The decoder needs funct7[5] at bit 30 and counters need a real width
    if (ILen < 31 || XLen < 1) begin : g_param_check
        $error("riscv_mc_ctrl: ILen must be >= 31 and XLen >= 1");
    end

    state_e    state_q;
    alu_op_e   alu_op;
    alu_ctrl_e alu_ctrl;

    // State register: sequences fetch/decode/execute/memory/writeback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    if (mem_ready_i) state_q <= DECODE;
                DECODE: begin
                    case (op_i)
                        OP_LOAD, OP_STORE: state_q <= MEMADR;
                        OP_R:              state_q <= EXECR;
                        OP_I:              state_q <= EXECI;
                        OP_BRANCH:         state_q <= BEQ;
                        OP_JAL:            state_q <= JAL;
                        default:           state_q <= TRAP;
                    endcase
                end
                MEMADR:   state_q <= (op_i == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready_i) state_q <= MEMWB;
                MEMWB:    state_q <= FETCH;
                MEMWRITE: if (mem_ready_i) state_q <= FETCH;
                EXECR:    state_q <= ALUWB;
                EXECI:    state_q <= ALUWB;
                ALUWB:    state_q <= FETCH;
                BEQ:      state_q <= FETCH;
                JAL:      state_q <= ALUWB;
                TRAP:     state_q <= TRAP;
                default:  state_q <= FETCH;
            endcase
        end
    end

    // Moore output decode; only the ready/zero gating depends on live inputs
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req_o    = 1'b1;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALURESULT;
            end
            DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
            end
            MEMWB: begin
                result_src_o = RES_DATA;
                reg_write_o  = 1'b1;
            end
            MEMWRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                adr_src_o = 1'b1;
            end
            EXECR: begin
                alu_src_a_o = SRCA_RS1;
                alu_op      = ALUOP_FUNCT;
            end
            EXECI: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write_o = 1'b1;
            end
            BEQ: begin
                alu_src_a_o = SRCA_RS1;
                alu_op      = ALUOP_SUB;
                pc_write_o  = zero_i;
            end
            JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_write_o  = 1'b1;
            end
            default: ;
        endcase
        // A reset cycle must never commit anything, even mid-instruction
        if (rst_i) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            reg_write_o = 1'b0;
        end
    end

    riscv_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3_i),
        .funct7b5    (funct7b5_i),
        .op5         (op_i[5]),
        .alu_control (alu_ctrl)
    );

    assign alu_control_o = alu_ctrl;
    assign imm_src_o     = imm_src_of(op_i);
    // TRAP is absorbing, so the flag is sticky until reset clears it
    assign illegal_o     = (state_q == TRAP) && !rst_i;

`ifdef RISCV_MC_CTRL_PERF_CNT_EN
    logic instret_evt;

    assign instret_evt = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                         ((state_q == MEMWRITE) && mem_ready_i);

    // Free-running cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o   <= '0;
            instret_cnt_o <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (instret_evt) begin
                instret_cnt_o <= instret_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for the multicycle controller.
// Observes a packed vector of control outputs once per cycle on the falling edge.
// Inputs change on the falling edge; checks happen 1 time unit later.
module tb_riscv_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic        illegal;
`ifdef RISCV_MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    riscv_mc_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .op_i          (op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .adr_src_o     (adr_src),
        .ir_write_o    (ir_write),
        .pc_write_o    (pc_write),
        .reg_write_o   (reg_write),
        .result_src_o  (result_src),
        .alu_src_a_o   (alu_src_a),
        .alu_src_b_o   (alu_src_b),
        .imm_src_o     (imm_src),
        .alu_control_o (alu_control),
        .illegal_o     (illegal)
`ifdef RISCV_MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt_o   (cycle_cnt),
        .instret_cnt_o (instret_cnt)
`endif
    );

    // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, result_src, a, b}
    logic [11:0] sig;
    assign sig = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b};

    localparam logic [11:0] S_FETCH_R = 12'b1_0_0_1_1_0_10_00_10;
    localparam logic [11:0] S_FETCH_W = 12'b1_0_0_0_0_0_10_00_10;
    localparam logic [11:0] S_DECODE  = 12'b0_0_0_0_0_0_00_01_01;
    localparam logic [11:0] S_MEMADR  = 12'b0_0_0_0_0_0_00_10_01;
    localparam logic [11:0] S_MEMREAD = 12'b1_0_1_0_0_0_00_00_00;
    localparam logic [11:0] S_MEMWB   = 12'b0_0_0_0_0_1_01_00_00;
    localparam logic [11:0] S_MEMWR   = 12'b1_1_1_0_0_0_00_00_00;
    localparam logic [11:0] S_EXECR   = 12'b0_0_0_0_0_0_00_10_00;
    localparam logic [11:0] S_EXECI   = 12'b0_0_0_0_0_0_00_10_01;
    localparam logic [11:0] S_ALUWB   = 12'b0_0_0_0_0_1_00_00_00;
    localparam logic [11:0] S_BEQ_T   = 12'b0_0_0_0_1_0_00_10_00;
    localparam logic [11:0] S_BEQ_N   = 12'b0_0_0_0_0_0_00_10_00;
    localparam logic [11:0] S_JAL     = 12'b0_0_0_0_1_0_00_01_10;
    localparam logic [11:0] S_RST     = 12'b0_0_0_0_0_0_10_00_10;

    // Leaves the DUT in FETCH with rst low, at a falling edge
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (sig !== S_RST) begin
            fails++; $display("FAIL reset_enables: got %b want %b", sig, S_RST);
        end
        tests++;
        if (illegal !== 1'b0) begin
            fails++; $display("FAIL reset_illegal: got %b want 0", illegal);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (sig !== S_FETCH_R) begin
            fails++; $display("FAIL reset_fetch: got %b want %b", sig, S_FETCH_R);
        end
    endtask

    task automatic test_lw();
        logic [11:0] exp_s [6];
        exp_s = '{S_FETCH_R, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_FETCH_R};
        do_reset();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (sig !== exp_s[i]) begin
                fails++; $display("FAIL lw_seq[%0d]: got %b want %b", i, sig, exp_s[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_wait();
        logic [11:0] exp_s [9];
        logic        rdy   [9];
        exp_s = '{S_FETCH_W, S_FETCH_R, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR, S_MEMWR, S_FETCH_R};
        rdy   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            tests++;
            if (sig !== exp_s[i]) begin
                fails++; $display("FAIL sw_seq[%0d]: got %b want %b", i, sig, exp_s[i]);
            end
            if (i == 2) begin
                tests++;
                if (imm_src !== 2'b01) begin
                    fails++; $display("FAIL sw_imm_src: got %b want 01", imm_src);
                end
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_beq();
        logic [11:0] exp_s [4];
        for (int z = 1; z >= 0; z--) begin
            exp_s = '{S_FETCH_R, S_DECODE, (z == 1) ? S_BEQ_T : S_BEQ_N, S_FETCH_R};
            do_reset();
            op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z[0];
            for (int i = 0; i < 4; i++) begin
                #1;
                tests++;
                if (sig !== exp_s[i]) begin
                    fails++; $display("FAIL beq_z%0d_seq[%0d]: got %b want %b", z, i, sig, exp_s[i]);
                end
                if (i == 2) begin
                    tests++;
                    if (alu_control !== 3'b001 || imm_src !== 2'b10) begin
                        fails++; $display("FAIL beq_alu_imm: got alu %b imm %b want alu 001 imm 10",
                                          alu_control, imm_src);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_alu_dec();
        logic [6:0]  c_op  [5];
        logic [2:0]  c_f3  [5];
        logic        c_f7  [5];
        logic [11:0] c_sig [5];
        logic [2:0]  c_alu [5];
        logic [11:0] exp_s;
        c_op  = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
        c_f3  = '{3'b000, 3'b000, 3'b111, 3'b010, 3'b110};
        c_f7  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        c_sig = '{S_EXECR, S_EXECI, S_EXECR, S_EXECI, S_EXECR};
        c_alu = '{3'b001, 3'b000, 3'b010, 3'b101, 3'b011};
        for (int c = 0; c < 5; c++) begin
            do_reset();
            op = c_op[c]; funct3 = c_f3[c]; funct7b5 = c_f7[c];
            for (int i = 0; i < 5; i++) begin
                case (i)
                    0, 4:    exp_s = S_FETCH_R;
                    1:       exp_s = S_DECODE;
                    2:       exp_s = c_sig[c];
                    default: exp_s = S_ALUWB;
                endcase
                #1;
                tests++;
                if (sig !== exp_s) begin
                    fails++; $display("FAIL alu_case%0d_seq[%0d]: got %b want %b", c, i, sig, exp_s);
                end
                if (i == 2) begin
                    tests++;
                    if (alu_control !== c_alu[c]) begin
                        fails++; $display("FAIL alu_case%0d_ctrl: got %b want %b", c, alu_control, c_alu[c]);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jal();
        logic [11:0] exp_s [5];
        exp_s = '{S_FETCH_R, S_DECODE, S_JAL, S_ALUWB, S_FETCH_R};
        do_reset();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (sig !== exp_s[i]) begin
                fails++; $display("FAIL jal_seq[%0d]: got %b want %b", i, sig, exp_s[i]);
            end
            if (i == 2) begin
                tests++;
                if (alu_control !== 3'b000 || imm_src !== 2'b11) begin
                    fails++; $display("FAIL jal_alu_imm: got alu %b imm %b want alu 000 imm 11",
                                      alu_control, imm_src);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        do_reset();
        op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (sig !== S_DECODE || illegal !== 1'b0) begin
            fails++; $display("FAIL trap_decode: got %b ill %b want %b ill 0", sig, illegal, S_DECODE);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (sig !== 12'd0 || illegal !== 1'b1) begin
                fails++; $display("FAIL trap_hold[%0d]: got %b ill %b want 0 ill 1", i, sig, illegal);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (illegal !== 1'b0) begin
            fails++; $display("FAIL trap_rst_clear: got %b want 0", illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (sig !== S_FETCH_R || illegal !== 1'b0) begin
            fails++; $display("FAIL trap_after_rst: got %b ill %b want %b ill 0", sig, illegal, S_FETCH_R);
        end
    endtask

    task automatic test_rst_in_memwb();
        do_reset();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (sig !== S_MEMWB) begin
            fails++; $display("FAIL memwb_reach: got %b want %b", sig, S_MEMWB);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (reg_write !== 1'b0) begin
            fails++; $display("FAIL memwb_rst_regwrite: got %b want 0", reg_write);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (sig !== S_FETCH_R) begin
            fails++; $display("FAIL memwb_rst_fetch: got %b want %b", sig, S_FETCH_R);
        end
    endtask

`ifdef RISCV_MC_CTRL_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
        #1;
        tests++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            fails++; $display("FAIL perf_clear: got cyc %0d ret %0d want 0 0", cycle_cnt, instret_cnt);
        end
        repeat (12) @(negedge clk);
        #1;
        tests++;
        if (cycle_cnt !== 32'd12 || instret_cnt !== 32'd3) begin
            fails++; $display("FAIL perf_3addi: got cyc %0d ret %0d want 12 3", cycle_cnt, instret_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_alu_dec();
        test_jal();
        test_trap();
        test_rst_in_memwb();
`ifdef RISCV_MC_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
